// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared encodings for the memory responder: access size codes,
//               FSM state type and wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Access size encodings carried on the size port
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Width of the wait-state down-counter (supports 0..15 wait cycles)
    localparam int c_wait_cnt_w = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_ram_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_ram_bank
// Description : DEPTH x 32 single-port synchronous RAM with per-byte write
//               strobes. Read data is registered and reflects the contents
//               before any write performed on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ram_bank #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Byte-masked write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-access responder for a core. Accepts one request at a
//               time, inserts WAIT_STATES wait cycles, checks alignment and
//               range, steers byte lanes and returns a one-cycle ready pulse
//               with load data or a fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int c_aw = $clog2(DEPTH);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_wait_cnt_w-1:0] r_cnt;
    logic [c_wait_cnt_w-1:0] w_next_cnt;
    logic                    w_accept;

    // Latched request; only the address bits that matter after the range
    // check are kept
    logic                    r_wr;
    logic [c_aw+1:0]         r_addr;
    logic [1:0]              r_size;
    logic [31:0]             r_wdata;
    logic                    r_fault;

    logic                    w_align_bad;
    logic                    w_range_bad;
    logic                    w_in_fault;

    logic [3:0]              w_strobe;
    logic [31:0]             w_lane_data;
    logic [3:0]              w_ram_we;
    logic                    w_ram_en;
    logic [c_aw-1:0]         w_ram_addr;
    logic [31:0]             w_ram_rdata;
    logic [31:0]             w_shifted;
    logic [31:0]             w_load;

    // Fault detection on the live request, evaluated while IDLE
    always_comb begin
        w_range_bad = (addr[31:c_aw+2] != '0);
        case (size)
            SZ_BYTE: w_align_bad = 1'b0;
            SZ_HALF: w_align_bad = addr[0];
            SZ_WORD: w_align_bad = (addr[1:0] != 2'b00);
            default: w_align_bad = 1'b1;
        endcase
        w_in_fault = w_align_bad | w_range_bad;
    end

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic; faulting accesses skip the wait phase
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (w_in_fault || (WAIT_STATES == 0)) begin
                        w_next_state = RESP;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = c_wait_cnt_w'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= c_wait_cnt_w'(1)) begin
                    w_next_state = RESP;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - c_wait_cnt_w'(1);
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Capture the request on acceptance so later input changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_wr    <= wr;
            r_addr  <= addr[c_aw+1:0];
            r_size  <= size;
            r_wdata <= wdata;
            r_fault <= w_in_fault;
        end
    end

    // Store lane steering (little-endian) and RAM port control
    always_comb begin
        case (r_size)
            SZ_BYTE: begin
                w_strobe    = 4'b0001 << r_addr[1:0];
                w_lane_data = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_strobe    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{r_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_strobe    = 4'b1111;
                w_lane_data = r_wdata;
            end
            default: begin
                w_strobe    = 4'b0000;
                w_lane_data = r_wdata;
            end
        endcase
        w_ram_we   = ((r_state == RESP) && r_wr && !r_fault) ? w_strobe : 4'b0000;
        // While IDLE the read is launched from the live address so a zero-wait
        // load has its data ready in the following RESP cycle
        w_ram_addr = (r_state == IDLE) ? addr[c_aw+1:2] : r_addr[c_aw+1:2];
        w_ram_en   = ((r_state == IDLE) && req) || (r_state == WAIT) || (w_ram_we != 4'b0000);
    end

    mem_ram_bank #(
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_lane_data),
        .o_rdata (w_ram_rdata)
    );

    // Load zero-extension and response outputs, all quiet outside RESP
    always_comb begin
        w_shifted = w_ram_rdata >> {r_addr[1:0], 3'b000};
        case (r_size)
            SZ_BYTE: w_load = {24'h0, w_shifted[7:0]};
            SZ_HALF: w_load = r_addr[1] ? {16'h0, w_ram_rdata[31:16]}
                                        : {16'h0, w_ram_rdata[15:0]};
            default: w_load = w_ram_rdata;
        endcase
        ready = (r_state == RESP);
        fault = (r_state == RESP) && r_fault;
        rdata = ((r_state == RESP) && !r_wr && !r_fault) ? w_load : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder with three
//               instances (WAIT_STATES = 1, 3 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        req1, req3, req0;
    logic        rdy1, rdy3, rdy0;
    logic        flt1, flt3, flt0;
    logic [31:0] rd1, rd3, rd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr), .addr(addr), .size(size),
        .wdata(wdata), .ready(rdy1), .rdata(rd1), .fault(flt1));

    mem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .wr(wr), .addr(addr), .size(size),
        .wdata(wdata), .ready(rdy3), .rdata(rd3), .fault(flt3));

    mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .wr(wr), .addr(addr), .size(size),
        .wdata(wdata), .ready(rdy0), .rdata(rd0), .fault(flt0));

    task automatic set_req(input int inst, input logic v);
        case (inst)
            0: req0 = v;
            3: req3 = v;
            default: req1 = v;
        endcase
    endtask

    task automatic get_out(input int inst, output logic r, output logic f, output logic [31:0] d);
        case (inst)
            0: begin r = rdy0; f = flt0; d = rd0; end
            3: begin r = rdy3; f = flt3; d = rd3; end
            default: begin r = rdy1; f = flt1; d = rd1; end
        endcase
    endtask

    // One access: request for one edge, scramble inputs, wait for ready
    task automatic access(input int inst, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat);
        logic        r, f;
        logic [31:0] d;
        @(negedge clk);
        wr = w; addr = a; size = sz; wdata = wd;
        set_req(inst, 1'b1);
        @(posedge clk);
        #1;
        set_req(inst, 1'b0);
        wr = ~w; addr = 32'hFFFF_FFFF; size = 2'b11; wdata = ~wd;
        lat = -1; rd = 32'h0; flt = 1'b0;
        for (int c = 1; (c <= 40) && (lat < 0); c++) begin
            @(negedge clk);
            get_out(inst, r, f, d);
            if (r) begin
                lat = c; rd = d; flt = f;
            end
        end
        if (lat >= 0) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req0 = 0; req1 = 0; req3 = 0;
        wr = 0; addr = 0; size = 0; wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rdy1, flt1, rd1} !== 34'h0) begin
            $display("FAIL reset_ws1 got=%h want=0", {rdy1, flt1, rd1}); bad++;
        end
        total++;
        if ({rdy3, flt3, rd3} !== 34'h0) begin
            $display("FAIL reset_ws3 got=%h want=0", {rdy3, flt3, rd3}); bad++;
        end
        total++;
        if ({rdy0, flt0, rd0} !== 34'h0) begin
            $display("FAIL reset_ws0 got=%h want=0", {rdy0, flt0, rd0}); bad++;
        end
        rst = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic f; int lat;
        access(1, 1'b1, 32'h10, 2'b10, 32'hDEADBEEF, rd, f, lat);
        total++;
        if ({f, rd} !== 33'h0 || lat !== 2) begin
            $display("FAIL word_store got f=%b rd=%h lat=%0d want f=0 rd=0 lat=2", f, rd, lat); bad++;
        end
        access(1, 1'b0, 32'h10, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'hDEADBEEF || f !== 1'b0 || lat !== 2) begin
            $display("FAIL word_load got f=%b rd=%h lat=%0d want f=0 rd=deadbeef lat=2", f, rd, lat); bad++;
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd; logic f; int lat;
        access(1, 1'b1, 32'h20, 2'b10, 32'h11223344, rd, f, lat);
        access(1, 1'b1, 32'h22, 2'b00, 32'h123456AA, rd, f, lat);
        total++;
        if (f !== 1'b0 || rd !== 32'h0 || lat !== 2) begin
            $display("FAIL byte_store got f=%b rd=%h lat=%0d want f=0 rd=0 lat=2", f, rd, lat); bad++;
        end
        access(1, 1'b0, 32'h20, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'h11AA3344 || f !== 1'b0) begin
            $display("FAIL byte_merge got f=%b rd=%h want f=0 rd=11aa3344", f, rd); bad++;
        end
        access(1, 1'b0, 32'h23, 2'b00, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'h00000011 || f !== 1'b0) begin
            $display("FAIL byte_load3 got f=%b rd=%h want f=0 rd=00000011", f, rd); bad++;
        end
        access(1, 1'b0, 32'h22, 2'b00, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'h000000AA || f !== 1'b0) begin
            $display("FAIL byte_load2 got f=%b rd=%h want f=0 rd=000000aa", f, rd); bad++;
        end
    endtask

    task automatic test_halfword;
        logic [31:0] rd; logic f; int lat;
        access(1, 1'b1, 32'h30, 2'b10, 32'h55667788, rd, f, lat);
        access(1, 1'b1, 32'h32, 2'b01, 32'h9999BEEF, rd, f, lat);
        access(1, 1'b0, 32'h30, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'hBEEF7788 || f !== 1'b0) begin
            $display("FAIL half_merge got f=%b rd=%h want f=0 rd=beef7788", f, rd); bad++;
        end
        access(1, 1'b0, 32'h32, 2'b01, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'h0000BEEF || f !== 1'b0) begin
            $display("FAIL half_load got f=%b rd=%h want f=0 rd=0000beef", f, rd); bad++;
        end
        access(1, 1'b0, 32'h30, 2'b01, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'h00007788 || f !== 1'b0) begin
            $display("FAIL half_load_lo got f=%b rd=%h want f=0 rd=00007788", f, rd); bad++;
        end
        access(1, 1'b0, 32'h31, 2'b01, 32'h0, rd, f, lat);
        total++;
        if (f !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            $display("FAIL half_misalign got f=%b rd=%h lat=%0d want f=1 rd=0 lat=1", f, rd, lat); bad++;
        end
    endtask

    task automatic test_faults;
        logic [31:0] rd; logic f; int lat;
        access(1, 1'b0, 32'h400, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (f !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            $display("FAIL range got f=%b rd=%h lat=%0d want f=1 rd=0 lat=1", f, rd, lat); bad++;
        end
        access(1, 1'b0, 32'h3FC, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (f !== 1'b0 || lat !== 2) begin
            $display("FAIL range_top got f=%b lat=%0d want f=0 lat=2", f, lat); bad++;
        end
        access(1, 1'b1, 32'h0, 2'b10, 32'hA5A5A5A5, rd, f, lat);
        access(1, 1'b1, 32'h0, 2'b11, 32'hFFFFFFFF, rd, f, lat);
        total++;
        if (f !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            $display("FAIL rsvd_store got f=%b rd=%h lat=%0d want f=1 rd=0 lat=1", f, rd, lat); bad++;
        end
        access(1, 1'b0, 32'h0, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'hA5A5A5A5 || f !== 1'b0) begin
            $display("FAIL rsvd_nowrite got f=%b rd=%h want f=0 rd=a5a5a5a5", f, rd); bad++;
        end
        access(1, 1'b1, 32'h22, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (f !== 1'b1 || lat !== 1) begin
            $display("FAIL word_misalign got f=%b lat=%0d want f=1 lat=1", f, lat); bad++;
        end
        access(1, 1'b0, 32'h20, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'h11AA3344) begin
            $display("FAIL misalign_nowrite got rd=%h want rd=11aa3344", rd); bad++;
        end
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] rd; logic f; int lat; logic seen;
        access(3, 1'b1, 32'h40, 2'b10, 32'h12345678, rd, f, lat);
        total++;
        if (lat !== 4 || f !== 1'b0) begin
            $display("FAIL ws3_store got f=%b lat=%0d want f=0 lat=4", f, lat); bad++;
        end
        @(negedge clk);
        wr = 1'b1; addr = 32'h40; size = 2'b10; wdata = 32'h5; req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        seen = 1'b0;
        @(negedge clk); seen |= rdy3;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); seen |= rdy3;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk); seen |= rdy3;
        end
        total++;
        if (seen !== 1'b0) begin
            $display("FAIL abort_ready got seen=%b want seen=0", seen); bad++;
        end
        access(3, 1'b0, 32'h40, 2'b10, 32'h0, rd, f, lat);
        total++;
        if (rd !== 32'h12345678 || f !== 1'b0 || lat !== 4) begin
            $display("FAIL abort_nowrite got f=%b rd=%h lat=%0d want f=0 rd=12345678 lat=4", f, rd, lat); bad++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic f; int lat;
        logic        exp_r;
        logic [31:0] exp_d;
        access(0, 1'b1, 32'h10, 2'b10, 32'hCAFEF00D, rd, f, lat);
        total++;
        if (lat !== 1 || f !== 1'b0) begin
            $display("FAIL ws0_store got f=%b lat=%0d want f=0 lat=1", f, lat); bad++;
        end
        @(negedge clk);
        wr = 1'b0; addr = 32'h10; size = 2'b10; wdata = 32'h0; req0 = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_r = (i % 2) == 1;
            exp_d = exp_r ? 32'hCAFEF00D : 32'h0;
            total++;
            if (rdy0 !== exp_r || rd0 !== exp_d || flt0 !== 1'b0) begin
                $display("FAIL b2b_cycle%0d got r=%b d=%h f=%b want r=%b d=%h f=0",
                         i, rdy0, rd0, flt0, exp_r, exp_d); bad++;
            end
        end
        req0 = 1'b0;
        @(negedge clk);
        total++;
        if (rdy0 !== 1'b0) begin
            $display("FAIL b2b_stop got r=%b want r=0", rdy0); bad++;
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte_lanes;
        test_halfword;
        test_faults;
        test_reset_mid_access;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words held; it is a power of two, at least 4.
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the wait cycles inserted before each non-faulting response (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 1 bit: the core requests a memory access.
REQ-006 SHALL have port wr, input, 1 bit: 1 means store, 0 means load.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-009 SHALL have port wdata, input, 32 bits: store data, right-aligned for byte and halfword stores.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle pulse that completes the access.
REQ-011 SHALL have port rdata, output, 32 bits: load data, valid only while ready=1.
REQ-012 SHALL have port fault, output, 1 bit: marks an errored access, valid only while ready=1.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1, SHALL latch wr, addr, size and wdata, then go to WAIT, or go directly to RESP if WAIT_STATES=0 or the access faults.
REQ-015 In WAIT, SHALL decrement a counter loaded with WAIT_STATES and go to RESP on the cycle after it reaches 1.
REQ-016 In RESP, SHALL drive ready=1 for exactly one cycle, then return to IDLE.
REQ-017 For a non-faulting access, load latency SHALL be WAIT_STATES+1 cycles from the req sample edge to ready; for a faulting access it SHALL be 1 cycle.
REQ-018 SHALL ignore req in WAIT and RESP; the earliest next acceptance is the IDLE cycle after RESP.
REQ-019 SHALL use only the latched request values; input changes after acceptance SHALL have no effect.
REQ-020 SHALL flag a fault when any of these holds:
  - size=11;
  - a halfword access has addr[0]=1;
  - a word access has addr[1:0]≠00;
  - addr ≥ 4·DEPTH.
REQ-021 On a fault, SHALL leave memory unmodified and drive rdata=0 with fault=1 and ready=1.
REQ-022 Stores SHALL be little-endian:
  - byte: wdata[7:0] written to lane addr[1:0];
  - halfword: wdata[15:0] written to lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes written;
  - other lanes unchanged.
REQ-023 A store SHALL commit in the RESP cycle, and rdata SHALL read 0 during a store response.
REQ-024 Loads SHALL zero-extend the addressed byte or halfword into rdata[31:0] (sign extension is the datapath's job).
REQ-025 Outside RESP, ready, fault and rdata SHALL all be 0.

Reset
REQ-026 When rst=1 at a clock edge, SHALL enter IDLE, clear the wait counter and latched request, and drive ready=0, fault=0, rdata=0.
REQ-027 A reset during WAIT SHALL abort the access, with no store committed and no ready pulse issued.
REQ-028 Memory contents SHALL NOT be reset.

Structure
REQ-029 The shared package SHALL hold:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum;
  - the WAIT_STATES counter width (4 bits).
REQ-030 SHALL instantiate one sub-module, mem_ram_bank: a DEPTH×32 synchronous RAM with a 4-bit byte-write strobe and one read/write port.
REQ-031 Alignment/range checking and lane steering SHALL be combinational logic inside mem_responder.

Verification
REQ-032 Word store/load, WAIT_STATES=1: store 0xDEADBEEF to 0x10, then load 0x10 → ready 2 cycles after req, rdata=0xDEADBEEF, fault=0.
REQ-033 Byte lanes: word 0x11223344 at 0x20, then byte store 0xAA to 0x22 → word load returns 0x11AA3344, and byte load of 0x23 returns 0x00000011.
REQ-034 Halfword: store 0xBEEF to 0x32, then load the word at 0x30 → rdata[31:16]=0xBEEF with the low half preserved; a halfword load at 0x31 → fault=1, rdata=0, ready 1 cycle after req.
REQ-035 Range and reserved size: with DEPTH=256, a word load at 0x400 → fault=1; a store with size=11 to 0x0 → fault=1 and memory at 0x0 unchanged.
REQ-036 Reset mid-access: WAIT_STATES=3, word store 0x5 to 0x40, rst asserted in the second WAIT cycle → no ready pulse, and a later load of 0x40 returns the prior value.
REQ-037 Throughput: WAIT_STATES=0 with req held high → a ready pulse every 2 cycles, and req samples during RESP are ignored.
